led_spi_receiver: RTL and testbench
===================================

LED_SPI_RECEIVER -- requirements
Module: led_spi_receiver

Interface
REQ-001 The block SHALL have parameter IDLE_TIMEOUT, default 64, meaning the number of clk cycles without an sclk edge that ends a frame.
REQ-002 The block SHALL have parameter ROWS, default 256, meaning the number of 400-bit rows per vsync period.
REQ-003 Port clk  in  1  system clock; all logic on posedge clk.
REQ-004 Port rst_n  in  1  reset, synchronous, active-low.
REQ-005 Port sclk  in  1  SPI clock from master; asynchronous to clk.
REQ-006 Port mosi  in  1  SPI data from master, MSB first, valid on sclk rising edge.
REQ-007 Port miso  out  1  status readback to master, MSB first, changed after sclk falling edge.
REQ-008 Port index_pulse  out  1  one-cycle pulse on a valid 0xAA10 index frame.
REQ-009 Port vsync_pulse  out  1  one-cycle pulse on a valid 0xAAF0 vsync frame.
REQ-010 Port reg_we  out  1  one-cycle register-write strobe.
REQ-011 Port reg_addr  out  3  register address 0..4, held until the next write.
REQ-012 Port reg_data  out  48  register payload, held until the next write.
REQ-013 Port row_valid  out  1  one-cycle pulse when a 400-bit row is complete.
REQ-014 Port row_data  out  400  last complete row, bit 399 = first received bit.
REQ-015 Port row_idx  out  8  index of the row on row_data, 0..ROWS-1.
REQ-016 Port frame_err  out  1  one-cycle pulse on any protocol error.

Function
REQ-017 sclk and mosi SHALL pass through a 2-FF synchronizer; sclk rise/fall SHALL be detected from the synchronized value; mosi SHALL be sampled on the detected rise, giving a 3-clk input latency.
REQ-018 The FSM SHALL have the states HDR, PAYLOAD, ROW and DISCARD; reset state is HDR.
REQ-019 In HDR, after 16 bits: if byte0 != 0xAA, the FSM SHALL pulse frame_err and go to DISCARD.
REQ-020 In HDR, cmd 0x10 SHALL pulse index_pulse, clear config_done, and return to HDR.
REQ-021 In HDR, cmd 0xF0 SHALL pulse vsync_pulse, clear the row counter, and go to ROW only if config_done=1; otherwise it SHALL pulse frame_err and return to HDR.
REQ-022 In HDR, cmd 0x00..0x04 SHALL go to PAYLOAD; any other cmd SHALL pulse frame_err and go to DISCARD.
REQ-023 In PAYLOAD, after 48 more bits (64 total) the block SHALL output reg_addr=cmd[2:0] and reg_data=payload, pulse reg_we, and return to HDR; a write to address 4 SHALL set config_done.
REQ-024 In ROW, every 400 bits the block SHALL update row_data and row_idx and pulse row_valid in the cycle after the 400th rise.
REQ-025 In ROW, the row counter SHALL increment; after row ROWS-1 the FSM SHALL return to HDR, and the counter SHALL wrap to 0.
REQ-026 If IDLE_TIMEOUT clk cycles pass without an sclk edge while a frame is partial (bit count != 0), the bit count SHALL clear and frame_err SHALL pulse.
REQ-027 On such a timeout, PAYLOAD and DISCARD SHALL return to HDR, while ROW SHALL stay in ROW with the row counter unchanged.
REQ-028 A timeout with zero bits pending SHALL have no effect.
REQ-029 DISCARD SHALL ignore bits and exit to HDR only on idle timeout, without a second frame_err.
REQ-030 The bit counter SHALL be 9 bits wide and reset on each frame completion.
REQ-031 The idle counter SHALL saturate at IDLE_TIMEOUT and clear on every sclk edge.
REQ-032 miso SHALL shift a 64-bit status word loaded at bit 0 of each frame: {8'h5A, config_done padded to 8 bits, rows_received[15:0], err_cnt[7:0], 24'h0}.
REQ-033 err_cnt SHALL saturate at 255; rows_received SHALL wrap.
REQ-034 If a frame completes in the same cycle as a timeout, frame completion SHALL win and no frame_err SHALL pulse.

Reset
REQ-035 While rst_n=0 at posedge clk, all outputs SHALL be 0 (miso=0, row_data=0, reg_data=0); the FSM SHALL be in HDR; all counters SHALL be 0; config_done SHALL be 0.
REQ-036 Reset asserted mid-frame SHALL discard the partial frame with no pulses; the next bit after release SHALL be bit 0 of a header.

Structure
REQ-037 Package led_spi_pkg SHALL hold HDR_BYTE=8'hAA, CMD_INDEX=8'h10, CMD_VSYNC=8'hF0, REG_LAST=3'd4, CMD_BITS=16, REG_BITS=64, ROW_BITS=400 and the FSM state enum; the existing controller SHALL share it.
REQ-038 The design SHALL contain one sub-module, spi_edge_sync (2-FF sync plus rise/fall pulse detection), instantiated for sclk, with mosi using its data path.

Verification
REQ-039 Send 0xAA10 -> exactly one index_pulse, no other strobes.
REQ-040 Send index, then 0xAA002000F0CF0107 -> reg_we with reg_addr=0, reg_data=48'h2000F0CF0107.
REQ-041 Send full init (index plus regs 0..4), then 0xAAF0, then 256 rows (row k = {k repeated}) -> 256 row_valid pulses, row_idx 0..255, FSM back in HDR.
REQ-042 Send 0xAAF0 before config -> frame_err and vsync_pulse, no row_valid after a following 400 bits.
REQ-043 Send 0x5510, idle 64 clk -> one frame_err, then 0xAA10 -> index_pulse.
REQ-044 Send a 200-bit partial row, idle 64 -> frame_err, row_idx unchanged; next 400 bits -> row_valid with the same row_idx.

Source files
------------

// File: rtl/led_spi_pkg.sv
// rtl/led_spi_pkg.sv - shared frame constants, FSM state type and status word builder
package led_spi_pkg;

   localparam logic [7:0] HDR_BYTE   = 8'hAA;
   localparam logic [7:0] CMD_INDEX  = 8'h10;
   localparam logic [7:0] CMD_VSYNC  = 8'hF0;
   localparam logic [2:0] REG_LAST   = 3'd4;
   localparam int         CMD_BITS   = 16;
   localparam int         REG_BITS   = 64;
   localparam int         ROW_BITS   = 400;
   localparam logic [7:0] STATUS_TAG = 8'h5A;

   typedef enum logic [1:0] {
      HDR,
      PAYLOAD,
      ROW,
      DISCARD
   } state_t;

   // Status word shifted out on miso, MSB first, once per frame
   function automatic logic [63:0] status_word(input logic       cfg_done,
                                               input logic [15:0] rows,
                                               input logic [7:0]  errs);
      return {STATUS_TAG, 7'd0, cfg_done, rows, errs, 24'd0};
   endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// rtl/spi_edge_sync.sv - two-flop synchronizer for sclk/mosi with sclk edge pulses
module spi_edge_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic i_sclk,
   input  logic i_data,
   output logic o_rise,
   output logic o_fall,
   output logic o_data
);

   logic [2:0] r_sclk_sync;
   logic [1:0] r_data_sync;

   // Bring sclk and mosi into the clk domain; the third sclk stage is the edge reference
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_sclk_sync <= '0;
         r_data_sync <= '0;
      end else begin
         r_sclk_sync <= {r_sclk_sync[1:0], i_sclk};
         r_data_sync <= {r_data_sync[0], i_data};
      end
   end

   assign o_rise = r_sclk_sync[1] & ~r_sclk_sync[2];
   assign o_fall = ~r_sclk_sync[1] & r_sclk_sync[2];
   assign o_data = r_data_sync[1];

endmodule

// File: rtl/led_spi_receiver.sv
// rtl/led_spi_receiver.sv - SPI frame receiver for LED index/vsync/register/row traffic
module led_spi_receiver
   import led_spi_pkg::*;
#(
   parameter int IDLE_TIMEOUT = 64,
   parameter int ROWS         = 256
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         sclk,
   input  logic         mosi,
   output logic         miso,
   output logic         index_pulse,
   output logic         vsync_pulse,
   output logic         reg_we,
   output logic [2:0]   reg_addr,
   output logic [47:0]  reg_data,
   output logic         row_valid,
   output logic [399:0] row_data,
   output logic [7:0]   row_idx,
   output logic         frame_err
);

   localparam int            IW       = $clog2(IDLE_TIMEOUT + 1);
   localparam logic [IW-1:0] IDLE_MAX = IW'(IDLE_TIMEOUT);
   localparam logic [7:0]    ROW_LAST = 8'(ROWS - 1);

   logic                w_rise;
   logic                w_fall;
   logic                w_bit;
   logic                w_timeout;
   logic [ROW_BITS-1:0] w_sr_next;
   logic [15:0]         w_hdr;

   logic [IW-1:0]       r_idle;
   state_t              r_state;
   logic [8:0]          r_bit_cnt;
   logic [ROW_BITS-1:0] r_sr;
   logic [2:0]          r_cmd;
   logic [7:0]          r_row_cnt;
   logic                r_config_done;
   logic [15:0]         r_rows_rcvd;
   logic [7:0]          r_err_cnt;
   logic [63:0]         r_status;

   spi_edge_sync u_sclk_sync (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_sclk (sclk),
      .i_data (mosi),
      .o_rise (w_rise),
      .o_fall (w_fall),
      .o_data (w_bit)
   );

   // The shift register already holds the incoming bit when a frame boundary is decoded
   assign w_sr_next = {r_sr[ROW_BITS-2:0], w_bit};
   assign w_hdr     = w_sr_next[15:0];
   // Single-cycle event on the cycle the idle counter reaches its limit
   assign w_timeout = ~(w_rise | w_fall) & (r_idle == IDLE_MAX - 1'b1);

   // Idle counter: cleared by any sclk edge, saturates at the timeout value
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_idle <= '0;
      end else if (w_rise | w_fall) begin
         r_idle <= '0;
      end else if (r_idle != IDLE_MAX) begin
         r_idle <= r_idle + 1'b1;
      end
   end

   // Error and row statistics reported through the miso status word
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_err_cnt   <= '0;
         r_rows_rcvd <= '0;
      end else begin
         if (frame_err && r_err_cnt != 8'hFF) begin
            r_err_cnt <= r_err_cnt + 8'd1;
         end
         if (row_valid) begin
            r_rows_rcvd <= r_rows_rcvd + 16'd1;
         end
      end
   end

   // Frame FSM: bit assembly, header decode, payload/row capture and registered strobes
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state       <= HDR;
         r_bit_cnt     <= '0;
         r_sr          <= '0;
         r_cmd         <= '0;
         r_row_cnt     <= '0;
         r_config_done <= 1'b0;
         r_status      <= '0;
         miso          <= 1'b0;
         index_pulse   <= 1'b0;
         vsync_pulse   <= 1'b0;
         reg_we        <= 1'b0;
         reg_addr      <= '0;
         reg_data      <= '0;
         row_valid     <= 1'b0;
         row_data      <= '0;
         row_idx       <= '0;
         frame_err     <= 1'b0;
      end else begin
         index_pulse <= 1'b0;
         vsync_pulse <= 1'b0;
         reg_we      <= 1'b0;
         row_valid   <= 1'b0;
         frame_err   <= 1'b0;

         // Readback data moves on the falling edge so the master sees it stable at the rise
         if (w_fall) begin
            miso     <= r_status[63];
            r_status <= {r_status[62:0], 1'b0};
         end

         if (w_rise) begin
            r_sr      <= w_sr_next;
            r_bit_cnt <= r_bit_cnt + 9'd1;
            if (r_bit_cnt == '0) begin
               r_status <= status_word(r_config_done, r_rows_rcvd, r_err_cnt);
            end
            case (r_state)
               HDR: begin
                  if (r_bit_cnt == 9'(CMD_BITS - 1)) begin
                     if (w_hdr[15:8] != HDR_BYTE) begin
                        frame_err <= 1'b1;
                        r_bit_cnt <= '0;
                        r_state   <= DISCARD;
                     end else if (w_hdr[7:0] == CMD_INDEX) begin
                        index_pulse   <= 1'b1;
                        r_config_done <= 1'b0;
                        r_bit_cnt     <= '0;
                     end else if (w_hdr[7:0] == CMD_VSYNC) begin
                        vsync_pulse <= 1'b1;
                        r_row_cnt   <= '0;
                        r_bit_cnt   <= '0;
                        if (r_config_done) begin
                           r_state <= ROW;
                        end else begin
                           frame_err <= 1'b1;
                        end
                     end else if (w_hdr[7:0] <= {5'd0, REG_LAST}) begin
                        // Bit count keeps running: header plus payload is one 64-bit frame
                        r_cmd   <= w_hdr[2:0];
                        r_state <= PAYLOAD;
                     end else begin
                        frame_err <= 1'b1;
                        r_bit_cnt <= '0;
                        r_state   <= DISCARD;
                     end
                  end
               end
               PAYLOAD: begin
                  if (r_bit_cnt == 9'(REG_BITS - 1)) begin
                     reg_we    <= 1'b1;
                     reg_addr  <= r_cmd;
                     reg_data  <= w_sr_next[47:0];
                     r_bit_cnt <= '0;
                     r_state   <= HDR;
                     if (r_cmd == REG_LAST) begin
                        r_config_done <= 1'b1;
                     end
                  end
               end
               ROW: begin
                  if (r_bit_cnt == 9'(ROW_BITS - 1)) begin
                     row_valid <= 1'b1;
                     row_data  <= w_sr_next;
                     row_idx   <= r_row_cnt;
                     r_bit_cnt <= '0;
                     if (r_row_cnt == ROW_LAST) begin
                        r_row_cnt <= '0;
                        r_state   <= HDR;
                     end else begin
                        r_row_cnt <= r_row_cnt + 8'd1;
                     end
                  end
               end
               DISCARD: begin
                  r_bit_cnt <= '0;
               end
               default: begin
                  r_state <= HDR;
               end
            endcase
         end else if (w_timeout) begin
            // DISCARD always leaves quietly; elsewhere only a partial frame is an error
            if (r_state == DISCARD) begin
               r_state <= HDR;
            end else if (r_bit_cnt != '0) begin
               r_bit_cnt <= '0;
               frame_err <= 1'b1;
               if (r_state == PAYLOAD) begin
                  r_state <= HDR;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_led_spi_receiver.sv
// tb/tb_led_spi_receiver.sv - directed self-checking bench for led_spi_receiver
module tb_led_spi_receiver;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         sclk;
   logic         mosi;
   logic         miso;
   logic         index_pulse;
   logic         vsync_pulse;
   logic         reg_we;
   logic [2:0]   reg_addr;
   logic [47:0]  reg_data;
   logic         row_valid;
   logic [399:0] row_data;
   logic [7:0]   row_idx;
   logic         frame_err;

   int checks   = 0;
   int failures = 0;
   int n_index  = 0;
   int n_vsync  = 0;
   int n_we     = 0;
   int n_row    = 0;
   int n_err    = 0;
   logic [63:0]  miso_cap = '0;
   logic [399:0] exp_row;

   always #5 clk = ~clk;

   led_spi_receiver #(.IDLE_TIMEOUT(64), .ROWS(4)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .sclk        (sclk),
      .mosi        (mosi),
      .miso        (miso),
      .index_pulse (index_pulse),
      .vsync_pulse (vsync_pulse),
      .reg_we      (reg_we),
      .reg_addr    (reg_addr),
      .reg_data    (reg_data),
      .row_valid   (row_valid),
      .row_data    (row_data),
      .row_idx     (row_idx),
      .frame_err   (frame_err)
   );

   // Count high cycles of each strobe, so a stretched pulse shows up as an extra count
   always @(negedge clk) begin
      if (index_pulse) n_index++;
      if (vsync_pulse) n_vsync++;
      if (reg_we)      n_we++;
      if (row_valid)   n_row++;
      if (frame_err)   n_err++;
   end

   task automatic check(input string tag, input logic [399:0] obs, input logic [399:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // One SPI mode-0 bit: miso is captured just before the rise, as a master would
   task automatic send_bit(input logic b);
      mosi = b;
      repeat (3) @(negedge clk);
      miso_cap = {miso_cap[62:0], miso};
      sclk = 1'b1;
      repeat (3) @(negedge clk);
      sclk = 1'b0;
   endtask

   task automatic send_word(input logic [63:0] w, input int n);
      for (int i = n - 1; i >= 0; i--) send_bit(w[i]);
      idle(4);
   endtask

   task automatic send_row(input logic [7:0] v, input int nbits);
      for (int i = 0; i < nbits; i++) send_bit(v[3'(7 - (i % 8))]);
      idle(4);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_miso"}, 400'(miso), 400'(0));
      check({tag, "_strobes"}, 400'({index_pulse, vsync_pulse, reg_we, row_valid, frame_err}), 400'(0));
      check({tag, "_reg"}, 400'({reg_addr, reg_data}), 400'(0));
      check({tag, "_row_data"}, row_data, 400'(0));
      check({tag, "_row_idx"}, 400'(row_idx), 400'(0));
   endtask

   initial begin
      rst_n = 1'b0;
      sclk  = 1'b0;
      mosi  = 1'b0;
      idle(3);
      check_reset_outputs("reset");
      rst_n = 1'b1;
      idle(4);

      // Single index frame
      send_word(64'hAA10, 16);
      check("idx_index", 400'(n_index), 400'(1));
      check("idx_others", 400'(n_vsync + n_we + n_row + n_err), 400'(0));
      check("idx_miso", 400'(miso_cap[14:0]), 400'(15'h2D00));
      idle(80);
      check("idle_no_pending", 400'(n_err), 400'(0));

      // Register 0 write after index
      send_word(64'hAA10, 16);
      send_word(64'hAA002000F0CF0107, 64);
      check("reg0_we", 400'(n_we), 400'(1));
      check("reg0_addr", 400'(reg_addr), 400'(0));
      check("reg0_data", 400'(reg_data), 400'(48'h2000F0CF0107));
      check("reg0_miso", 400'(miso_cap[62:0]), 400'(64'h5A00000000000000 >> 1));

      // Remaining config registers, vsync, then a full set of rows
      send_word(64'hAA01111122223333, 64);
      send_word(64'hAA02444455556666, 64);
      send_word(64'hAA03777788889999, 64);
      send_word(64'hAA04000000000001, 64);
      check("reg4_we", 400'(n_we), 400'(5));
      check("reg4_addr", 400'(reg_addr), 400'(4));
      check("reg4_data", 400'(reg_data), 400'(48'h000000000001));
      send_word(64'hAAF0, 16);
      check("vsync_ok", 400'(n_vsync), 400'(1));
      check("vsync_ok_err", 400'(n_err), 400'(0));
      for (int k = 0; k < 4; k++) begin
         send_row(8'(k), 400);
         exp_row = {50{8'(k)}};
         check($sformatf("row%0d_count", k), 400'(n_row), 400'(k + 1));
         check($sformatf("row%0d_idx", k), 400'(row_idx), 400'(k));
         check($sformatf("row%0d_data", k), row_data, exp_row);
      end

      // Back in header mode: a register write decodes and status shows config and rows
      send_word(64'hAA00123456789ABC, 64);
      check("post_rows_we", 400'(n_we), 400'(6));
      check("post_rows_data", 400'(reg_data), 400'(48'h123456789ABC));
      check("post_rows_miso", 400'(miso_cap[62:0]), 400'(64'h5A01000400000000 >> 1));
      send_word(64'hAA10, 16);
      check("post_rows_index", 400'(n_index), 400'(3));

      // Vsync without configuration
      send_word(64'hAAF0, 16);
      check("vsync_nocfg_pulse", 400'(n_vsync), 400'(2));
      check("vsync_nocfg_err", 400'(n_err), 400'(1));
      send_row(8'h00, 400);
      idle(80);
      check("vsync_nocfg_norow", 400'(n_row), 400'(4));
      check("vsync_nocfg_discard_err", 400'(n_err), 400'(2));

      // Bad header byte, idle, then recovery
      send_word(64'h5510, 16);
      check("badhdr_err", 400'(n_err), 400'(3));
      idle(80);
      check("badhdr_idle_err", 400'(n_err), 400'(3));
      send_word(64'hAA10, 16);
      check("badhdr_recover", 400'(n_index), 400'(4));

      // Partial row timeout keeps the row counter
      send_word(64'hAA04000000000001, 64);
      check("cfg2_miso", 400'(miso_cap[62:0]), 400'(64'h5A00000403000000 >> 1));
      send_word(64'hAAF0, 16);
      check("vsync2_err", 400'(n_err), 400'(3));
      send_row(8'hA5, 400);
      check("row_a5_idx", 400'(row_idx), 400'(0));
      send_row(8'h33, 200);
      idle(80);
      check("partial_err", 400'(n_err), 400'(4));
      check("partial_norow", 400'(n_row), 400'(5));
      check("partial_idx", 400'(row_idx), 400'(0));
      send_row(8'h5C, 400);
      exp_row = {50{8'h5C}};
      check("after_partial_count", 400'(n_row), 400'(6));
      check("after_partial_idx", 400'(row_idx), 400'(1));
      check("after_partial_data", row_data, exp_row);

      // Reset in the middle of a row frame
      for (int i = 0; i < 8; i++) send_bit(1'b1);
      rst_n = 1'b0;
      idle(3);
      check_reset_outputs("midreset");
      rst_n = 1'b1;
      idle(4);
      send_word(64'hAA10, 16);
      check("midreset_index", 400'(n_index), 400'(5));
      check("midreset_err", 400'(n_err), 400'(4));
      check("midreset_miso", 400'(miso_cap[14:0]), 400'(15'h2D00));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
